// File: rtl/alif_channel_sequencer.sv
// ---------------------------------------------------------------------------
// alif_channel_sequencer
//   Time-multiplexes one shared ALIF neuron update datapath across NUM_CH
//   channels. Holds per-channel membrane (v), adaptation (a) and input
//   current (cur) registers; on each step request every channel is issued
//   to the datapath in order, results are written back and the spike vector
//   of the completed step is published.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   ena_i                      0 freezes the sequencer (cfg writes still land)
//   step_req_i                 start one time step (sampled in IDLE)
//   clear_i                    zero all v/a (IDLE only)
//   err_clr_i                  clear sticky err_o / overrun_o
//   cfg_we_i/cfg_ch_i/cfg_cur_i write cur[cfg_ch_i]
//   dp_valid_o, dp_v_o, dp_a_o, dp_i_o   operands to the datapath
//   dp_rdy_i, dp_v_nxt_i, dp_a_nxt_i, dp_spike_i   datapath result
//   busy_o, step_done_o, spike_vec_o, err_o, overrun_o   status
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for step_req; clear accepted here
// ISSUE  | channel ch_q presented to datapath, waiting for dp_rdy/timeout
// DONE   | step complete, one cycle before returning to IDLE
// ---------------------------------------------------------------------------
module alif_channel_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ena_i,
    input  logic                      step_req_i,
    input  logic                      clear_i,
    input  logic                      err_clr_i,
    input  logic                      cfg_we_i,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch_i,
    input  logic [W-1:0]              cfg_cur_i,
    output logic                      dp_valid_o,
    output logic [W-1:0]              dp_v_o,
    output logic [W-1:0]              dp_a_o,
    output logic [W-1:0]              dp_i_o,
    input  logic                      dp_rdy_i,
    input  logic [W-1:0]              dp_v_nxt_i,
    input  logic [W-1:0]              dp_a_nxt_i,
    input  logic                      dp_spike_i,
    output logic                      busy_o,
    output logic                      step_done_o,
    output logic [NUM_CH-1:0]         spike_vec_o,
    output logic                      err_o,
    output logic                      overrun_o
);

    localparam int CHW = $clog2(NUM_CH);
    localparam int CW  = $clog2(TIMEOUT);
    localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CH - 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CHW-1:0]     ch_q, ch_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_CH-1:0]  acc_q, acc_d;
    logic [NUM_CH-1:0]  spike_vec_q, spike_vec_d;
    logic               step_done_q, step_done_d;
    logic               err_q, err_d;
    logic               overrun_q, overrun_d;
    logic [W-1:0]       v_q   [NUM_CH];
    logic [W-1:0]       v_d   [NUM_CH];
    logic [W-1:0]       a_q   [NUM_CH];
    logic [W-1:0]       a_d   [NUM_CH];
    logic [W-1:0]       cur_q [NUM_CH];
    logic [W-1:0]       cur_d [NUM_CH];
    logic               adv;
    logic               err_set;
    logic               busy;

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        spike_vec_d = spike_vec_q;
        step_done_d = 1'b0;
        v_d         = v_q;
        a_d         = a_q;
        cur_d       = cur_q;
        adv         = 1'b0;
        err_set     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ena_i && step_req_i) begin
                    state_d = S_ISSUE;
                    ch_d    = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (clear_i) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        v_d[i] = '0;
                        a_d[i] = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (ena_i) begin
                    if (dp_rdy_i) begin
                        v_d[ch_q]   = dp_v_nxt_i;
                        a_d[ch_q]   = dp_a_nxt_i;
                        acc_d[ch_q] = dp_spike_i;
                        adv         = 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        // timed-out channel keeps its state and reports no spike
                        acc_d[ch_q] = 1'b0;
                        err_set     = 1'b1;
                        adv         = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (adv) begin
                        cnt_d = '0;
                        if (ch_q == CH_LAST) begin
                            spike_vec_d = acc_d;
                            state_d     = S_DONE;
                        end else begin
                            ch_d = ch_q + CHW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                // step_done is registered on leaving DONE, so it lands one
                // cycle after spike_vec updates
                if (ena_i) begin
                    step_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cfg_we_i) begin
            cur_d[cfg_ch_i] = cfg_cur_i;
        end

        // a set in the same cycle as err_clr wins
        err_d     = err_set | (err_q & ~err_clr_i);
        overrun_d = (busy & step_req_i) | (overrun_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            spike_vec_q <= '0;
            step_done_q <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                v_q[i]   <= '0;
                a_q[i]   <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            spike_vec_q <= spike_vec_d;
            step_done_q <= step_done_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < NUM_CH; i++) begin
                v_q[i]   <= v_d[i];
                a_q[i]   <= a_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    assign dp_valid_o  = (state_q == S_ISSUE) && ena_i;
    assign dp_v_o      = v_q[ch_q];
    assign dp_a_o      = a_q[ch_q];
    assign dp_i_o      = cur_q[ch_q];
    assign busy_o      = busy;
    assign step_done_o = step_done_q;
    assign spike_vec_o = spike_vec_q;
    assign err_o       = err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_alif_channel_sequencer.sv
module tb_alif_channel_sequencer;

    localparam int NUM_CH  = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 8;
    localparam int CHW     = $clog2(NUM_CH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic              step_req = 1'b0;
    logic              clear = 1'b0;
    logic              err_clr = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CHW-1:0]    cfg_ch = '0;
    logic [W-1:0]      cfg_cur = '0;
    logic              dp_valid;
    logic [W-1:0]      dp_v, dp_a, dp_i;
    logic              dp_rdy = 1'b1;
    logic [W-1:0]      dp_v_nxt, dp_a_nxt;
    logic              dp_spike;
    logic              busy, step_done, err, overrun;
    logic [NUM_CH-1:0] spike_vec;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] v;
        logic [W-1:0] a;
        logic [W-1:0] i;
    } op_t;

    op_t               exp_ops[$];
    logic [NUM_CH-1:0] exp_spk[$];
    logic [W-1:0]      m_v   [NUM_CH];
    logic [W-1:0]      m_a   [NUM_CH];
    logic [W-1:0]      m_cur [NUM_CH];

    always #5 clk = ~clk;

    // datapath stub: v' = v + i, spike when v' >= 64 and then v' -= 64; a' = a + spike
    logic [W:0] dp_sum;
    assign dp_sum   = {1'b0, dp_v} + {1'b0, dp_i};
    assign dp_spike = (dp_sum >= (W+1)'(64));
    assign dp_v_nxt = dp_spike ? W'(dp_sum - (W+1)'(64)) : dp_sum[W-1:0];
    assign dp_a_nxt = dp_a + W'(dp_spike);

    alif_channel_sequencer #(
        .NUM_CH (NUM_CH),
        .W      (W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ena_i      (ena),
        .step_req_i (step_req),
        .clear_i    (clear),
        .err_clr_i  (err_clr),
        .cfg_we_i   (cfg_we),
        .cfg_ch_i   (cfg_ch),
        .cfg_cur_i  (cfg_cur),
        .dp_valid_o (dp_valid),
        .dp_v_o     (dp_v),
        .dp_a_o     (dp_a),
        .dp_i_o     (dp_i),
        .dp_rdy_i   (dp_rdy),
        .dp_v_nxt_i (dp_v_nxt),
        .dp_a_nxt_i (dp_a_nxt),
        .dp_spike_i (dp_spike),
        .busy_o     (busy),
        .step_done_o(step_done),
        .spike_vec_o(spike_vec),
        .err_o      (err),
        .overrun_o  (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model of one completed step; pushes operand and spike expectations
    task automatic push_step();
        logic [W:0]        s;
        logic [NUM_CH-1:0] sv;
        sv = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_ops.push_back('{v: m_v[c], a: m_a[c], i: m_cur[c]});
            s = {1'b0, m_v[c]} + {1'b0, m_cur[c]};
            if (s >= 64) begin
                sv[c]  = 1'b1;
                m_v[c] = W'(s - 64);
                m_a[c] = m_a[c] + 1'b1;
            end else begin
                m_v[c] = s[W-1:0];
            end
        end
        exp_spk.push_back(sv);
    endtask

    task automatic cfg_all();
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_we   = 1'b1;
            cfg_ch   = CHW'(c);
            cfg_cur  = W'((c + 1) * 10);
            m_cur[c] = W'((c + 1) * 10);
            tick();
        end
        cfg_we = 1'b0;
    endtask

    // exp_lat counts edges after the edge that samples step_req until step_done is seen
    task automatic run_step(input int exp_lat, input int ena_at, input int rdy_at,
                            input int clr_at, input bit tmo, input int hold);
        int n;
        if (tmo) exp_spk.push_back('0);
        else     push_step();
        dp_rdy   = !tmo;
        step_req = 1'b1;
        tick();
        n = 0;
        while (!step_done && n < 200) begin
            step_req = (n < hold - 1);
            ena      = !(ena_at >= 0 && n >= ena_at && n < ena_at + 3);
            dp_rdy   = !tmo && (n != rdy_at);
            clear    = (n == clr_at);
            tick();
            n++;
            if (!ena) chk("dp_valid_ena0", dp_valid, 1'b0);
            if (n == 1) chk("busy_in_step", busy, 1'b1);
        end
        step_req = 1'b0;
        ena      = 1'b1;
        dp_rdy   = 1'b1;
        clear    = 1'b0;
        chk("step_latency", n, exp_lat);
        tick();
        chk("step_done_pulse", step_done, 1'b0);
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (dp_valid && dp_rdy) begin
                chk("op_expected", (exp_ops.size() != 0), 1'b1);
                if (exp_ops.size() != 0) begin
                    op_t e;
                    e = exp_ops.pop_front();
                    chk("dp_v", dp_v, e.v);
                    chk("dp_a", dp_a, e.a);
                    chk("dp_i", dp_i, e.i);
                end
            end
            if (step_done) begin
                chk("done_expected", (exp_spk.size() != 0), 1'b1);
                if (exp_spk.size() != 0) chk("spike_vec", spike_vec, exp_spk.pop_front());
            end
        end
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_v[c] = '0; m_a[c] = '0; m_cur[c] = '0;
        end
        repeat (2) tick();
        chk("rst_dp_valid", dp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_step_done", step_done, 1'b0);
        chk("rst_spike_vec", spike_vec, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_dp_v", dp_v, '0);
        chk("rst_dp_a", dp_a, '0);
        chk("rst_dp_i", dp_i, '0);
        rst_n = 1'b1;
        tick();
        cfg_all();

        // two plain steps: v ends at {20,40,60,16}, only channel 3 spikes
        run_step(NUM_CH + 1, -1, -1, -1, 1'b0, 1);
        run_step(NUM_CH + 1, -1, -1, -1, 1'b0, 1);
        chk("spike_vec_step2", spike_vec, 4'b1000);
        chk("no_overrun", overrun, 1'b0);

        // datapath never ready: every channel times out
        run_step(NUM_CH * TIMEOUT + 1, -1, -1, -1, 1'b1, 1);
        chk("tmo_err", err, 1'b1);
        chk("tmo_spike_vec", spike_vec, '0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", err, 1'b0);

        // v/a untouched by the timeout step
        run_step(NUM_CH + 1, -1, -1, -1, 1'b0, 1);

        // step_req held for three cycles: one step, overrun flagged
        run_step(NUM_CH + 1, -1, -1, -1, 1'b0, 3);
        chk("overrun_set", overrun, 1'b1);
        repeat (3) tick();
        chk("no_second_step", busy, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("overrun_cleared", overrun, 1'b0);

        // ena dropped for 3 cycles while channel 2 is issued
        run_step(NUM_CH + 1 + 3, 2, -1, -1, 1'b0, 1);

        // one-cycle dp_rdy stall on channel 1
        run_step(NUM_CH + 2, -1, 1, -1, 1'b0, 1);
        chk("short_stall_err", err, 1'b0);

        // clear in IDLE zeroes v/a
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_v[c] = '0; m_a[c] = '0;
        end
        run_step(NUM_CH + 1, -1, -1, -1, 1'b0, 1);

        // clear while busy is ignored
        run_step(NUM_CH + 1, -1, -1, 1, 1'b0, 1);
        run_step(NUM_CH + 1, -1, -1, -1, 1'b0, 1);

        // async reset in the middle of ISSUE
        push_step();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #2;
        chk("arst_dp_valid", dp_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_step_done", step_done, 1'b0);
        chk("arst_spike_vec", spike_vec, '0);
        chk("arst_err", err, 1'b0);
        chk("arst_overrun", overrun, 1'b0);
        chk("arst_dp_v", dp_v, '0);
        chk("arst_dp_i", dp_i, '0);
        exp_ops.delete();
        exp_spk.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            m_v[c] = '0; m_a[c] = '0; m_cur[c] = '0;
        end
        tick();
        rst_n = 1'b1;
        tick();
        cfg_all();
        run_step(NUM_CH + 1, -1, -1, -1, 1'b0, 1);

        chk("ops_left", exp_ops.size(), 0);
        chk("spk_left", exp_spk.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
